// File: rtl/ldst_agu.sv
// Load/store address generation unit: single and register-list transfers with optional base writeback.
// Defining LDST_ALIGN_CHK_EN adds the align_fault output and rejects misaligned requests.
module ldst_agu #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     p_bit,
  input  logic                     u_bit,
  input  logic                     w_bit,
  input  logic                     multi,
  input  logic [1:0]               size,
  input  logic [DATA_W-1:0]        rn,
  input  logic [DATA_W-1:0]        op2,
  input  logic [NREG-1:0]          reg_list,
  input  logic                     mem_ack,
  output logic                     mem_req,
  output logic [DATA_W-1:0]        mem_addr,
  output logic [$clog2(NREG)-1:0]  mem_reg,
  output logic                     busy,
  output logic                     done,
  output logic                     wb_en,
  output logic [DATA_W-1:0]        wb_val
`ifdef LDST_ALIGN_CHK_EN
  ,
  output logic                     align_fault
`endif
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t              state_q;
  logic                mem_req_q, done_q, wb_en_q, w_q, multi_q;
  logic [DATA_W-1:0]   mem_addr_q, wb_val_q;
  logic [RW-1:0]       mem_reg_q;
  logic [NREG-1:0]     rem_q, rem_next;
  logic [DATA_W-1:0]   four_n, first_addr, first_wb;
`ifdef LDST_ALIGN_CHK_EN
  logic                align_fault_q, fault_d;
`endif

  function automatic logic [RW-1:0] lowest(input logic [NREG-1:0] v);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (v[i] && !found) begin
        lowest = RW'(i);
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    four_n   = DATA_W'($countones(reg_list)) << 2;
    rem_next = rem_q & (rem_q - NREG'(1));
    if (multi) begin
      first_wb = u_bit ? rn + four_n : rn - four_n;
      case ({p_bit, u_bit})
        2'b01:   first_addr = rn;
        2'b11:   first_addr = rn + DATA_W'(4);
        2'b00:   first_addr = rn - four_n + DATA_W'(4);
        default: first_addr = rn - four_n;
      endcase
    end else begin
      first_wb   = u_bit ? rn + op2 : rn - op2;
      first_addr = p_bit ? first_wb : rn;
    end
`ifdef LDST_ALIGN_CHK_EN
    fault_d = 1'b0;
    if (multi)              fault_d = (first_addr[1:0] != 2'b00);
    else if (size == 2'b01) fault_d = first_addr[0];
    else if (size[1])       fault_d = (first_addr[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      done_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      w_q        <= 1'b0;
      multi_q    <= 1'b0;
      mem_addr_q <= '0;
      wb_val_q   <= '0;
      mem_reg_q  <= '0;
      rem_q      <= '0;
`ifdef LDST_ALIGN_CHK_EN
      align_fault_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LDST_ALIGN_CHK_EN
      align_fault_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            w_q        <= w_bit;
            multi_q    <= multi;
            rem_q      <= reg_list;
            mem_addr_q <= first_addr;
            wb_val_q   <= first_wb;
            mem_reg_q  <= multi ? lowest(reg_list) : '0;
`ifdef LDST_ALIGN_CHK_EN
            if (fault_d) begin
              done_q        <= 1'b1;
              align_fault_q <= 1'b1;
            end else
`endif
            if (multi && reg_list == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= XFER;
              mem_req_q <= 1'b1;
            end
          end
        end
        XFER: begin
          // mem_req is always high in XFER, so mem_ack here is a completed beat
          if (mem_ack) begin
            if (multi_q && rem_next != '0) begin
              rem_q      <= rem_next;
              mem_addr_q <= mem_addr_q + DATA_W'(4);
              mem_reg_q  <= lowest(rem_next);
            end else begin
              mem_req_q <= 1'b0;
              done_q    <= 1'b1;
              if (w_q) begin
                state_q <= WB;
                wb_en_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        WB: begin
          wb_en_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_reg  = mem_reg_q;
  assign done     = done_q;
  assign wb_en    = wb_en_q;
  assign wb_val   = wb_val_q;
`ifdef LDST_ALIGN_CHK_EN
  assign align_fault = align_fault_q;
`endif

endmodule

// File: tb/tb_ldst_agu.sv
// Scoreboard bench for ldst_agu: directed scenarios plus random transfers against a behavioural model.
module tb_ldst_agu;
  localparam int DW = 32;
  localparam int NR = 8;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic          p_bit = 1'b0, u_bit = 1'b0, w_bit = 1'b0, multi = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [DW-1:0] rn = '0, op2 = '0;
  logic [NR-1:0] reg_list = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req, busy, done, wb_en;
  logic [DW-1:0] mem_addr, wb_val;
  logic [2:0]    mem_reg;
`ifdef LDST_ALIGN_CHK_EN
  logic          align_fault;
`endif

  ldst_agu #(.DATA_W(DW), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit),
    .multi(multi), .size(size), .rn(rn), .op2(op2), .reg_list(reg_list), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_reg(mem_reg), .busy(busy), .done(done),
    .wb_en(wb_en), .wb_val(wb_val)
`ifdef LDST_ALIGN_CHK_EN
    , .align_fault(align_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [2:0] rg; bit chk_rg; } beat_t;
  typedef struct { bit wb; bit flt; logic [31:0] val; } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  done_t dm;
  int errors = 0, checks = 0, acked = 0, ack_mode = -1;
  int ack_cnt = 0, ack_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none/timeout-free", name);
  endtask

  function automatic int pick_wait();
    return (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
  endfunction

  // Behavioural model: beats and completion expected for one accepted request
  task automatic push_model(input bit p, u, w, m, input logic [1:0] sz,
                            input logic [31:0] b, o, input logic [7:0] lst);
    int n, k;
    logic [31:0] a, wbv;
    bit flt;
    beat_t bt;
    done_t d;
    n = 0; k = 0; flt = 0;
    for (int i = 0; i < NR; i++) if (lst[i]) n++;
    if (m) begin
      wbv = u ? b + 32'(4 * n) : b - 32'(4 * n);
      a   = u ? (p ? b + 32'd4 : b) : (p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4);
    end else begin
      wbv = u ? b + o : b - o;
      a   = p ? wbv : b;
    end
`ifdef LDST_ALIGN_CHK_EN
    flt = m ? (a[1:0] != 2'b00) : (sz == 2'b01 ? a[0] : (sz[1] && a[1:0] != 2'b00));
`else
    if (sz == 2'b11) flt = 0;
`endif
    if (!flt) begin
      if (m) begin
        for (int i = 0; i < NR; i++) begin
          if (lst[i]) begin
            bt.addr = a + 32'(4 * k); bt.rg = 3'(i); bt.chk_rg = 1;
            beat_q.push_back(bt);
            k++;
          end
        end
      end else begin
        bt.addr = a; bt.rg = 3'd0; bt.chk_rg = 0;
        beat_q.push_back(bt);
      end
    end
    d.wb = w && !flt && (!m || n != 0);
    d.flt = flt;
    d.val = wbv;
    done_q.push_back(d);
  endtask

  task automatic issue(input bit p, u, w, m, input logic [1:0] sz,
                       input logic [31:0] b, o, input logic [7:0] lst);
    int guard;
    guard = 0;
    // junk starts while busy must be ignored by the DUT
    while (busy && guard < 300) begin
      start = 1'($urandom_range(0, 1));
      rn = $urandom; op2 = $urandom; reg_list = 8'($urandom);
      p_bit = 1'($urandom); u_bit = 1'($urandom); w_bit = 1'($urandom); multi = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) fail_now("idle_timeout");
    p_bit = p; u_bit = u; w_bit = w; multi = m; size = sz; rn = b; op2 = o; reg_list = lst;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_model(p, u, w, m, sz, b, o, lst);
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_reg", mem_reg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_val", wb_val, 0);
`ifdef LDST_ALIGN_CHK_EN
    check("rst_align_fault", align_fault, 0);
`endif
  endtask

  // Memory responder: per-beat wait of ack_mode cycles (or random), noise on mem_ack when idle
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mem_ack = 1'b0; ack_cnt = 0;
      end else if (mem_req) begin
        if (ack_cnt >= ack_wait) begin
          mem_ack = 1'b1; ack_cnt = 0; ack_wait = pick_wait();
        end else begin
          mem_ack = 1'b0; ack_cnt++;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); ack_cnt = 0; ack_wait = pick_wait();
      end
    end
  end

  // Monitor: compares presented beats and completions against the scoreboard queues
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req) begin
          check("busy_with_req", busy, 1);
          if (beat_q.size() == 0) fail_now("unexpected_beat");
          else begin
            check("beat_addr", mem_addr, beat_q[0].addr);
            if (beat_q[0].chk_rg) check("beat_reg", mem_reg, beat_q[0].rg);
            if (mem_ack) begin
              void'(beat_q.pop_front());
              acked++;
            end
          end
        end
        if (done || wb_en) begin
          if (done_q.size() == 0) fail_now("unexpected_done");
          else begin
            dm = done_q.pop_front();
            check("done", done, 1);
            check("wb_en", wb_en, dm.wb);
            check("busy_at_done", busy, dm.wb);
            check("beats_left", beat_q.size(), 0);
            if (dm.wb) check("wb_val", wb_val, dm.val);
`ifdef LDST_ALIGN_CHK_EN
            check("align_fault", align_fault, dm.flt);
`endif
          end
        end
      end
    end
  end

  initial begin
    int g, a0;
    logic [7:0] lst;
    #12;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;

    ack_mode = 0;
    issue(1, 1, 1, 0, 2'b10, 32'h1000, 32'h10, 8'h00);
    ack_mode = 3;
    issue(0, 0, 0, 0, 2'b10, 32'h2000, 32'h8, 8'h00);
    ack_mode = -1;
    issue(1, 0, 1, 1, 2'b00, 32'h3000, 32'h0, 8'b10010110);
    issue(0, 1, 1, 1, 2'b01, 32'h1234, 32'h0, 8'h00);
    issue(1, 1, 0, 0, 2'b10, 32'hFFFF_FFFC, 32'h8, 8'h00);
    issue(0, 0, 1, 1, 2'b10, 32'h0000_0008, 32'h0, 8'hFF);
`ifdef LDST_ALIGN_CHK_EN
    issue(0, 1, 0, 0, 2'b10, 32'h1002, 32'h4, 8'h00);
`endif

    // Abort a four-beat list transfer after two beats complete
    a0 = acked;
    issue(0, 1, 1, 1, 2'b10, 32'h5000, 32'h0, 8'b11110000);
    g = 0;
    while (acked < a0 + 2 && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 100) fail_now("abort_wait_timeout");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    beat_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1, 1, 1, 1, 2'b10, 32'h4000, 32'h0, 8'b00000101);

    for (int t = 0; t < 40; t++) begin
      lst = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            $urandom, $urandom, lst);
    end

    g = 0;
    while ((busy || beat_q.size() != 0 || done_q.size() != 0) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
